// File: rtl/team_06_audio_pkg.sv
// Shared types for the team_06 audio effect engine: effect modes, FSM
// states and small decode helpers used by the engine and its bench.
package team_06_audio_pkg;

  typedef enum logic [2:0] {
    PASS   = 3'd0,
    ECHO   = 3'd1,
    REVERB = 3'd2,
    CRUSH  = 3'd3,
    TREM   = 3'd4
  } effect_mode_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WAIT_RD = 3'd2,
    CALC    = 3'd3,
    WR      = 3'd4,
    WAIT_WR = 3'd5,
    OUT     = 3'd6
  } ae_state_t;

  // Select codes above TREM have no effect assigned and fall back to passthrough.
  function automatic effect_mode_t decode_sel(input logic [2:0] s);
    return (s > 3'd4) ? PASS : effect_mode_t'(s);
  endfunction

  // Echo and reverb are the only modes that touch the SRAM engine.
  function automatic logic is_mem_mode(input effect_mode_t m);
    return (m == ECHO) || (m == REVERB);
  endfunction

endpackage

// File: rtl/team_06_audio_effect_engine_trem_lfo.sv
// Tremolo LFO: counts completed samples and walks the gain along a
// triangle wave, one gain step every TREM_DIV samples.
module team_06_trem_lfo #(
  parameter int GAIN_W   = 3,
  parameter int TREM_DIV = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  output logic [GAIN_W-1:0] gain
);

  localparam int                CNT_W    = (TREM_DIV > 1) ? $clog2(TREM_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TREM_DIV - 1);
  localparam logic [GAIN_W-1:0] G_MAX    = {GAIN_W{1'b1}};

  logic [CNT_W-1:0]  cnt_q;
  logic [GAIN_W-1:0] gain_q;
  logic              down_q;

  // Sample divider plus triangle walk; each extreme is visited for one step, then reversed.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      gain_q <= G_MAX;
      down_q <= 1'b1;
    end else if (step) begin
      if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
        if (down_q) begin
          if (gain_q == '0) begin
            gain_q <= gain_q + GAIN_W'(1);
            down_q <= 1'b0;
          end else begin
            gain_q <= gain_q - GAIN_W'(1);
          end
        end else begin
          if (gain_q == G_MAX) begin
            gain_q <= gain_q - GAIN_W'(1);
            down_q <= 1'b1;
          end else begin
            gain_q <= gain_q + GAIN_W'(1);
          end
        end
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign gain = gain_q;

endmodule

// File: rtl/team_06_audio_effect_engine.sv
// Per-sample audio effect engine. One rising edge of `finished` produces one
// processed sample; echo and reverb round-trip through the SRAM R/W engine
// with a bounded wait on mem_busy.
module team_06_audio_effect_engine
  import team_06_audio_pkg::*;
#(
  parameter int SAMPLE_W   = 8,
  parameter int CRUSH_BITS = 4,
  parameter int GAIN_W     = 3,
  parameter int TREM_DIV   = 256,
  parameter int TIMEOUT    = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] audio_in,
  input  logic                finished,
  input  logic [2:0]          sel,
  input  logic                audio_enable,
  input  logic [SAMPLE_W-1:0] past_output,
  input  logic                mem_busy,
  output logic [SAMPLE_W-1:0] audio_out,
  output logic                search,
  output logic                record,
  output logic [SAMPLE_W-1:0] save_audio,
  output logic                sample_done,
  output logic                mem_err
);

  localparam int               TMO_W    = $clog2(TIMEOUT + 1);
  localparam int               PROD_W   = SAMPLE_W + GAIN_W + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  // Mean of two samples; the sum carries one extra bit so 255+255 cannot wrap.
  function automatic logic [SAMPLE_W-1:0] avg_fn(input logic [SAMPLE_W-1:0] a,
                                                 input logic [SAMPLE_W-1:0] b);
    logic [SAMPLE_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return SAMPLE_W'(sum >> 1);
  endfunction

  function automatic logic [SAMPLE_W-1:0] crush_fn(input logic [SAMPLE_W-1:0] s);
    return s & ({SAMPLE_W{1'b1}} << CRUSH_BITS);
  endfunction

  // Gain g maps to (g+1)/2^GAIN_W, so the top gain is unity and nothing saturates.
  function automatic logic [SAMPLE_W-1:0] trem_fn(input logic [SAMPLE_W-1:0] s,
                                                  input logic [GAIN_W-1:0]   g);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(s) * (PROD_W'(g) + PROD_W'(1));
    return SAMPLE_W'(prod >> GAIN_W);
  endfunction

  function automatic logic [SAMPLE_W-1:0] calc_fn(input effect_mode_t        m,
                                                  input logic [SAMPLE_W-1:0] s,
                                                  input logic [SAMPLE_W-1:0] p,
                                                  input logic [GAIN_W-1:0]   g);
    case (m)
      ECHO, REVERB: return avg_fn(s, p);
      CRUSH:        return crush_fn(s);
      TREM:         return trem_fn(s, g);
      default:      return s;
    endcase
  endfunction

  ae_state_t           state_q, state_d;
  effect_mode_t        mode_q;
  logic                fin_q, trig_q, trig_take, timeout_hit;
  logic [TMO_W-1:0]    tmo_q;
  logic [SAMPLE_W-1:0] smp_q, past_q, result_q, audio_out_q, save_q;
  logic                sample_done_q, mem_err_q;
  logic [GAIN_W-1:0]   gain;

  // The trigger is registered, so a strobe edge only counts while fully idle.
  assign trig_take = finished & ~fin_q & audio_enable & ~trig_q & (state_q == IDLE);

  team_06_trem_lfo #(
    .GAIN_W   (GAIN_W),
    .TREM_DIV (TREM_DIV)
  ) u_lfo (
    .clk  (clk),
    .rst  (rst),
    .step (sample_done_q),
    .gain (gain)
  );

  // Next-state decode and the one-cycle memory request strobes.
  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    search      = 1'b0;
    record      = 1'b0;
    case (state_q)
      IDLE: begin
        if (trig_q && audio_enable) state_d = is_mem_mode(mode_q) ? REQ : CALC;
      end
      REQ: begin
        search  = 1'b1;
        state_d = WAIT_RD;
      end
      WAIT_RD, WAIT_WR: begin
        if (!mem_busy) begin
          state_d = (state_q == WAIT_RD) ? CALC : OUT;
        end else if (tmo_q == TMO_LAST) begin
          timeout_hit = 1'b1;
          state_d     = OUT;
        end
      end
      CALC:    state_d = is_mem_mode(mode_q) ? WR : OUT;
      WR: begin
        record  = 1'b1;
        state_d = WAIT_WR;
      end
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      fin_q         <= 1'b0;
      trig_q        <= 1'b0;
      tmo_q         <= '0;
      audio_out_q   <= '0;
      save_q        <= '0;
      sample_done_q <= 1'b0;
      mem_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      fin_q         <= finished;
      trig_q        <= trig_take;
      tmo_q         <= ((state_d == state_q) && (state_q == WAIT_RD || state_q == WAIT_WR))
                       ? tmo_q + TMO_W'(1) : '0;
      sample_done_q <= (state_q == OUT);
      mem_err_q     <= timeout_hit;
      if (!audio_enable)         audio_out_q <= '0;
      else if (state_q == OUT)   audio_out_q <= result_q;
      if (state_q == CALC && mode_q == ECHO)        save_q <= smp_q;
      else if (state_q == CALC && mode_q == REVERB) save_q <= avg_fn(smp_q, past_q);
    end
  end

  // Transaction data: latched at trigger, read capture, and the computed result.
  always_ff @(posedge clk) begin
    if (trig_take) begin
      mode_q <= decode_sel(sel);
      smp_q  <= audio_in;
    end
    if (state_q == WAIT_RD && !mem_busy) past_q <= past_output;
    if (timeout_hit)            result_q <= smp_q;
    else if (state_q == CALC)   result_q <= calc_fn(mode_q, smp_q, past_q, gain);
  end

  assign audio_out   = audio_out_q;
  assign save_audio  = save_q;
  assign sample_done = sample_done_q;
  assign mem_err     = mem_err_q;

endmodule

// File: tb/tb_team_06_audio_effect_engine.sv
// Bench for team_06_audio_effect_engine: directed transactions push their
// hand-computed expectations into a scoreboard, and a monitor pops and checks
// them whenever sample_done fires.
module tb_team_06_audio_effect_engine;
  import team_06_audio_pkg::*;

  typedef struct {
    logic [7:0] out;
    logic [7:0] save;
    int         srch;
    int         rec;
    int         merr;
    int         lat;
    int         t0;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, finished, audio_enable;
  logic [2:0] sel;
  logic [7:0] audio_in, past_output;
  logic       mem_busy = 1'b0;
  logic [7:0] audio_out, save_audio;
  logic       search, record, sample_done, mem_err;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0, n_fail = 0, cyc = 0;
  int   busy_len = 0, bcnt = 0;
  logic stuck_busy = 1'b0;
  int   srch_cnt = 0, rec_cnt = 0, merr_cnt = 0;
  logic both = 1'b0, hold = 1'b0, unstable = 1'b0;
  logic [7:0] save_cap = '0;

  always #5 clk = ~clk;

  team_06_audio_effect_engine #(
    .SAMPLE_W (8), .CRUSH_BITS (4), .GAIN_W (3), .TREM_DIV (1), .TIMEOUT (16)
  ) dut (
    .clk (clk), .rst (rst), .audio_in (audio_in), .finished (finished), .sel (sel),
    .audio_enable (audio_enable), .past_output (past_output), .mem_busy (mem_busy),
    .audio_out (audio_out), .search (search), .record (record), .save_audio (save_audio),
    .sample_done (sample_done), .mem_err (mem_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] out, input logic [7:0] save,
                              input int srch, input int rec, input int merr, input int lat);
    exp_t e;
    e.out = out; e.save = save; e.srch = srch; e.rec = rec; e.merr = merr; e.lat = lat; e.t0 = 0;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM engine stand-in: stays busy for busy_len cycles after each request.
  always @(negedge clk) begin
    if (search || record) bcnt = busy_len;
    else if (bcnt > 0)    bcnt = bcnt - 1;
    mem_busy = stuck_busy || (bcnt > 0);
  end

  // Monitor: accumulate strobe activity, check a transaction on each sample_done.
  always @(negedge clk) begin
    if (rst) begin
      srch_cnt = 0; rec_cnt = 0; merr_cnt = 0; both = 0; hold = 0; unstable = 0;
    end else begin
      if (search) srch_cnt++;
      if (record) begin
        rec_cnt++; save_cap = save_audio; hold = 1'b1;
      end else if (hold && save_audio !== save_cap) begin
        unstable = 1'b1;
      end
      if (search && record) both = 1'b1;
      if (mem_err) merr_cnt++;
      if (sample_done) begin
        chk("txn_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("audio_out", audio_out, mon_e.out);
          chk("search_pulses", srch_cnt, mon_e.srch);
          chk("record_pulses", rec_cnt, mon_e.rec);
          chk("mem_err_pulses", merr_cnt, mon_e.merr);
          chk("search_record_overlap", both, 0);
          if (mon_e.rec != 0) begin
            chk("save_audio", save_cap, mon_e.save);
            chk("save_stable", unstable, 0);
          end
          if (mon_e.lat != 0) chk("latency", cyc - mon_e.t0 - 1, mon_e.lat);
        end
        srch_cnt = 0; rec_cnt = 0; merr_cnt = 0; both = 0; hold = 0; unstable = 0;
      end
    end
  end

  task automatic wait_drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("txn_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  // One transaction; inputs are scrambled after the trigger edge to prove they were latched.
  task automatic run(input logic [2:0] s, input logic [7:0] a, input logic [7:0] p,
                     input int bl, input exp_t e);
    @(negedge clk);
    sel = s; audio_in = a; past_output = p; busy_len = bl; finished = 1'b1;
    e.t0 = cyc;
    sb.push_back(e);
    @(negedge clk);
    finished = 1'b0; sel = 3'd6; audio_in = 8'hA5;
    wait_drain();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; finished = 1'b0; sel = '0; audio_in = '0; past_output = '0; audio_enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_audio_out", audio_out, 0);
    chk("rst_save_audio", save_audio, 0);
    chk("rst_search", search, 0);
    chk("rst_record", record, 0);
    chk("rst_sample_done", sample_done, 0);
    chk("rst_mem_err", mem_err, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Tremolo walk from reset: g = 7, 6, 5, 4
    run(3'd4, 8'd200, 8'd0, 0, mk(8'd200, 8'd0, 0, 0, 0, 3));
    run(3'd4, 8'd200, 8'd0, 0, mk(8'd175, 8'd0, 0, 0, 0, 3));
    run(3'd4, 8'd200, 8'd0, 0, mk(8'd150, 8'd0, 0, 0, 0, 3));
    run(3'd4, 8'd200, 8'd0, 0, mk(8'd125, 8'd0, 0, 0, 0, 3));
    // Pass, bitcrush, unused select code
    run(3'd0, 8'd64,   8'd0, 0, mk(8'd64,   8'd0, 0, 0, 0, 3));
    run(3'd3, 8'h5B,   8'd0, 0, mk(8'h50,   8'd0, 0, 0, 0, 3));
    run(3'd7, 8'h33,   8'd0, 0, mk(8'h33,   8'd0, 0, 0, 0, 3));
    // Echo with a slow memory, then with an idle memory at minimum latency
    run(3'd1, 8'd64,  8'd32, 2, mk(8'd48,  8'd64,  1, 1, 0, 0));
    run(3'd1, 8'd100, 8'd50, 0, mk(8'd75,  8'd100, 1, 1, 0, 7));
    // Reverb feedback, including the full-scale no-overflow corner
    run(3'd2, 8'd64,  8'd200, 2, mk(8'd132, 8'd132, 1, 1, 0, 0));
    run(3'd2, 8'd255, 8'd255, 0, mk(8'd255, 8'd255, 1, 1, 0, 7));

    // Read timeout with a second strobe edge arriving mid-wait
    stuck_busy = 1'b1;
    @(negedge clk);
    sel = 3'd1; audio_in = 8'd77; past_output = 8'd10; busy_len = 0; finished = 1'b1;
    mon_e = mk(8'd77, 8'd0, 1, 0, 1, 0);
    sb.push_back(mon_e);
    @(negedge clk); finished = 1'b0;
    repeat (5) @(negedge clk);
    finished = 1'b1;
    @(negedge clk); finished = 1'b0;
    wait_drain();
    stuck_busy = 1'b0;
    repeat (20) @(negedge clk);

    // Mute
    audio_enable = 1'b0;
    @(negedge clk);
    chk("mute_out_next_cycle", audio_out, 0);
    sel = 3'd1; audio_in = 8'd99; finished = 1'b1;
    @(negedge clk); finished = 1'b0;
    repeat (10) @(negedge clk);
    chk("mute_no_search", srch_cnt, 0);
    chk("mute_out_held", audio_out, 0);
    audio_enable = 1'b1;
    repeat (2) @(negedge clk);

    // Reset while waiting on the write
    busy_len = 6;
    sel = 3'd1; audio_in = 8'd64; past_output = 8'd32; finished = 1'b1;
    @(negedge clk); finished = 1'b0;
    for (int i = 0; i < 50 && !record; i++) @(negedge clk);
    chk("record_before_reset", record, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_audio_out", audio_out, 0);
    chk("midrst_save_audio", save_audio, 0);
    chk("midrst_search", search, 0);
    chk("midrst_record", record, 0);
    chk("midrst_sample_done", sample_done, 0);
    chk("midrst_mem_err", mem_err, 0);
    chk("midrst_state", dut.state_q, IDLE);
    rst = 1'b0; busy_len = 0;
    repeat (20) @(negedge clk);
    chk("no_record_after_reset", rec_cnt, 0);

    run(3'd0, 8'd10, 8'd0, 0, mk(8'd10, 8'd0, 0, 0, 0, 3));
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/team_06_audio_effect_engine.md
# team_06_audio_effect_engine

Parametrised successor to the team's single-sample audio effect stage. It sits between the ADC sample path and the `team_06_readWrite` SRAM engine, is triggered once per sample by the `finished` strobe, and produces one processed sample per strobe. It has five selectable effects (passthrough, echo, reverb, bitcrush, tremolo), a generic sample width, and a bounded-latency SRAM handshake with timeout.

## Interface
Parameters:
- `SAMPLE_W`, default 8: unsigned audio sample width.
- `CRUSH_BITS`, default 4: number of LSBs zeroed in bitcrush mode; must be less than `SAMPLE_W`.
- `GAIN_W`, default 3: tremolo gain resolution.
- `TREM_DIV`, default 256: samples per tremolo gain step.
- `TIMEOUT`, default 64: maximum cycles to wait on `mem_busy`.

Ports:
- `clk`  in  1  system clock. Single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `audio_in`  in  SAMPLE_W  current input sample.
- `finished`  in  1  sample strobe. Its rising edge triggers processing.
- `sel`  in  3  mode select: 0 pass, 1 echo, 2 reverb, 3 bitcrush, 4 tremolo. Values 5–7 act as pass.
- `audio_enable`  in  1  when low, the output is muted and no new transactions start.
- `past_output`  in  SAMPLE_W  delayed sample returned by the R/W engine.
- `mem_busy`  in  1  R/W engine busy.
- `audio_out`  out  SAMPLE_W  processed sample, registered.
- `search`  out  1  one-cycle read request.
- `record`  out  1  one-cycle write request.
- `save_audio`  out  SAMPLE_W  sample to write. Held stable from `record` until `mem_busy` falls.
- `sample_done`  out  1  one-cycle pulse when `audio_out` updates.
- `mem_err`  out  1  one-cycle pulse on timeout.

## Operation
- Trigger: `fin_q` registers `finished`. A trigger is `finished & ~fin_q`, and is taken only in IDLE with `audio_enable` high. Triggers in any other state are ignored, not queued.
- At trigger, latch `sel` → `mode` and `audio_in` → `smp`. Changes to `sel` or `audio_in` mid-transaction have no effect on that transaction.
- States: IDLE, REQ, WAIT_RD, CALC, WR, WAIT_WR, OUT.
- Memory modes (echo, reverb): IDLE → REQ (`search`=1) → WAIT_RD → CALC → WR (`record`=1) → WAIT_WR → OUT → IDLE.
- Non-memory modes: IDLE → CALC → OUT → IDLE. `search` and `record` are never asserted.
- WAIT_RD and WAIT_WR:
  - Wait at least 1 cycle, then exit on the first cycle with `mem_busy`=0.
  - WAIT_RD captures `past_output` on that exit cycle.
  - A timeout counter counts cycles in the state. On reaching `TIMEOUT`: pulse `mem_err`, set result = `smp`, go to OUT, and skip WR.
- Arithmetic, all unsigned, with intermediate sums `SAMPLE_W`+1 bits wide:
  - echo: out = (smp + past) >> 1; save = smp.
  - reverb: out = (smp + past) >> 1; save = out (feedback).
  - bitcrush: out = smp with the low `CRUSH_BITS` bits cleared.
  - tremolo: out = (smp × (g+1)) >> `GAIN_W`, computed with a product width of `SAMPLE_W`+`GAIN_W`+1.
  - pass: out = smp.
- Tremolo LFO:
  - Gain `g` is in the range 0..2^`GAIN_W`−1 and forms a triangle wave.
  - `g` starts at its maximum and is direction-down after reset.
  - It steps by 1 every `TREM_DIV` completed samples, in every mode. At 0 and at max it reverses direction; the value at each extreme is held for exactly one step.
- When `audio_enable`=0: `audio_out` is registered to 0 on the next cycle. Any in-flight transaction still completes its memory handshake, but OUT writes 0.

## Timing
- Reset values:
  - `audio_out`, `save_audio`: 0.
  - `search`, `record`, `sample_done`, `mem_err`: 0.
  - State: IDLE. `fin_q`: 0. `g`: max. LFO counter: 0.
- Reset mid-transaction aborts immediately; no `record` is issued afterward.
- Edge numbering: the edge that samples `finished`=1 with `fin_q`=0 is edge 0.
- Non-memory latency: CALC at edge 1, OUT at edge 2. `audio_out` and `sample_done` are valid after edge 3.
- Memory latency: `search` is high during the cycle after edge 1.
  - Total latency = 3 + read wait (≥1) + 1 + write wait (≥1) + 1 cycles.
  - Minimum is 7 edges with `mem_busy` held at 0.
- `save_audio` is registered in CALC and stays stable through WAIT_WR.
- `search` and `record` are never both high, and each is exactly 1 cycle wide.

## Structure
- Package `team_06_audio_pkg` holds:
  - `effect_mode_t` enum: PASS, ECHO, REVERB, CRUSH, TREM.
  - `ae_state_t` enum for the seven states.
- Sub-module `team_06_trem_lfo` holds the sample counter and triangle gain. Its interface is `clk`, `rst`, `step` (= `sample_done`), and `gain`.

## Test plan
- Pass: `sel`=0, `audio_in`=64, raise `finished` → `audio_out`=64 and `sample_done` after edge 3. No `search` or `record`.
- Echo: `sel`=1, `audio_in`=64, `past_output`=32, `mem_busy` high for 2 cycles after each request → `audio_out`=48, `save_audio`=64, one `search` pulse, one `record` pulse.
- Reverb: `sel`=2, in=64, past=200 → `audio_out`=132 and `save_audio`=132. With in=255, past=255 → 255, with no overflow.
- Bitcrush and tremolo:
  - `sel`=3, in=0x5B → 0x50.
  - `sel`=4, in=200, first sample after reset → 200.
  - With `TREM_DIV`=1, successive outputs are 200, 175, 150, 125 (g = 7, 6, 5, 4).
- Timeout and retrigger: `sel`=1 with `mem_busy` stuck high and `TIMEOUT`=16 → `mem_err` pulse, `audio_out`=`audio_in`, no `record`. A `finished` edge arriving during WAIT_RD is ignored.
- Mute and reset: `audio_enable`=0 → `audio_out`=0 and no `search`. Assert `rst` during WAIT_WR → all outputs 0 next cycle and state is IDLE.
